// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn sequencer: owns both boards, validates human moves, commits the strategy pick, detects win/draw.
// Latency: human handshake -> comp_move_valid in 3+SETTLE cycles; human_ready_o is the only backpressure (high in WAIT_HUMAN).
module ttt_turn_controller #(
   parameter int NUM_RULES   = 8,
   parameter int SETTLE      = 1,
   parameter bit HUMAN_FIRST = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic                   human_valid_i,
   input  logic [8:0]             human_move_i,
   output logic                   human_ready_o,
   input  logic [9*NUM_RULES-1:0] rule_moves_i,
   output logic [8:0]             human_board_o,
   output logic [8:0]             computer_board_o,
   output logic [8:0]             comp_move_o,
   output logic                   comp_move_valid_o,
   output logic                   move_error_o,
   output logic                   game_over_o,
   output logic [1:0]             winner_o
);

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WAIT_HUMAN = 3'd1;
   localparam logic [2:0] ST_H_CHECK    = 3'd2;
   localparam logic [2:0] ST_SETTLE     = 3'd3;
   localparam logic [2:0] ST_SELECT     = 3'd4;
   localparam logic [2:0] ST_C_CHECK    = 3'd5;
   localparam logic [2:0] ST_OVER       = 3'd6;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_HUMAN = 2'b01;
   localparam logic [1:0] WIN_COMP  = 2'b10;

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;

   // With SETTLE=0 the wait state is bypassed entirely.
   localparam logic [2:0] ST_PRE_SELECT = (SETTLE == 0) ? ST_SELECT : ST_SETTLE;
   localparam logic [2:0] ST_FIRST      = HUMAN_FIRST ? ST_WAIT_HUMAN : ST_PRE_SELECT;

   logic [2:0]       state_q, state_d;
   logic [8:0]       human_board_q, human_board_d;
   logic [8:0]       computer_board_q, computer_board_d;
   logic [8:0]       comp_move_q, comp_move_d;
   logic [1:0]       winner_q, winner_d;
   logic             move_error_q, move_error_d;
   logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;

   logic [8:0] occupied;
   logic [8:0] empty_sq;
   logic [8:0] pick;
   logic       human_legal;
   logic       board_full;

   function automatic logic line_hit(input logic [8:0] b, input logic [8:0] m);
      return (b & m) == m;
   endfunction

   function automatic logic has_line(input logic [8:0] b);
      return line_hit(b, 9'b111000000) || line_hit(b, 9'b000111000) ||
             line_hit(b, 9'b000000111) || line_hit(b, 9'b100100100) ||
             line_hit(b, 9'b010010010) || line_hit(b, 9'b001001001) ||
             line_hit(b, 9'b100010001) || line_hit(b, 9'b001010100);
   endfunction

   function automatic logic [8:0] msb_onehot(input logic [8:0] v);
      logic [8:0] r;
      r = '0;
      for (int i = 0; i < 9; i++) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic is_onehot(input logic [8:0] v);
      return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
   endfunction

   // Scanning from the lowest priority upwards lets rule 0 overwrite everything else.
   function automatic logic [8:0] select_pick(input logic [9*NUM_RULES-1:0] rules,
                                              input logic [8:0]             empty_v);
      logic [8:0] res;
      logic [8:0] cand;
      res = msb_onehot(empty_v);
      for (int k = NUM_RULES - 1; k >= 0; k--) begin
         cand = rules[9*k +: 9] & empty_v;
         if (cand != 9'd0) begin
            res = msb_onehot(cand);
         end
      end
      return res;
   endfunction

   assign occupied    = human_board_q | computer_board_q;
   assign empty_sq    = ~occupied;
   assign board_full  = &occupied;
   assign pick        = select_pick(rule_moves_i, empty_sq);
   assign human_legal = is_onehot(human_move_i) && ((human_move_i & occupied) == 9'd0);

   always_comb begin
      state_d          = state_q;
      human_board_d    = human_board_q;
      computer_board_d = computer_board_q;
      comp_move_d      = comp_move_q;
      winner_d         = winner_q;
      settle_cnt_d     = settle_cnt_q;
      move_error_d     = 1'b0;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_i) begin
               human_board_d    = '0;
               computer_board_d = '0;
               comp_move_d      = '0;
               winner_d         = WIN_NONE;
               settle_cnt_d     = '0;
               state_d          = ST_FIRST;
            end
         end
         ST_WAIT_HUMAN: begin
            if (human_valid_i) begin
               if (human_legal) begin
                  human_board_d = human_board_q | human_move_i;
                  state_d       = ST_H_CHECK;
               end else begin
                  move_error_d = 1'b1;
               end
            end
         end
         ST_H_CHECK: begin
            if (has_line(human_board_q)) begin
               winner_d = WIN_HUMAN;
               state_d  = ST_OVER;
            end else if (board_full) begin
               winner_d = WIN_NONE;
               state_d  = ST_OVER;
            end else begin
               state_d = ST_PRE_SELECT;
            end
         end
         ST_SETTLE: begin
            // Counter leaves SETTLE at zero so the next entry starts fresh.
            if (settle_cnt_q == CNT_LAST) begin
               settle_cnt_d = '0;
               state_d      = ST_SELECT;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         ST_SELECT: begin
            comp_move_d      = pick;
            computer_board_d = computer_board_q | pick;
            state_d          = ST_C_CHECK;
         end
         ST_C_CHECK: begin
            if (has_line(computer_board_q)) begin
               winner_d = WIN_COMP;
               state_d  = ST_OVER;
            end else if (board_full) begin
               winner_d = WIN_NONE;
               state_d  = ST_OVER;
            end else begin
               state_d = ST_WAIT_HUMAN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q          <= ST_IDLE;
         human_board_q    <= '0;
         computer_board_q <= '0;
         comp_move_q      <= '0;
         winner_q         <= WIN_NONE;
         move_error_q     <= 1'b0;
         settle_cnt_q     <= '0;
      end else begin
         state_q          <= state_d;
         human_board_q    <= human_board_d;
         computer_board_q <= computer_board_d;
         comp_move_q      <= comp_move_d;
         winner_q         <= winner_d;
         move_error_q     <= move_error_d;
         settle_cnt_q     <= settle_cnt_d;
      end
   end

   assign human_ready_o     = (state_q == ST_WAIT_HUMAN);
   assign comp_move_valid_o = (state_q == ST_C_CHECK);
   assign game_over_o       = (state_q == ST_OVER);
   assign human_board_o     = human_board_q;
   assign computer_board_o  = computer_board_q;
   assign comp_move_o       = comp_move_q;
   assign move_error_o      = move_error_q;
   assign winner_o          = winner_q;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Bench for ttt_turn_controller: directed scenarios plus random games against a square-array game model.
module tb_ttt_turn_controller;
   localparam int NR = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, start, human_valid;
   logic [8:0]    human_move;
   logic [9*NR-1:0] rule_moves;

   logic       a_ready, a_cmv, a_err, a_over;
   logic [8:0] a_hb, a_cb, a_cm;
   logic [1:0] a_win;
   logic       b_ready, b_cmv, b_err, b_over;
   logic [8:0] b_hb, b_cb, b_cm;
   logic [1:0] b_win;
   logic       c_ready, c_cmv, c_err, c_over;
   logic [8:0] c_hb, c_cb, c_cm;
   logic [1:0] c_win;

   ttt_turn_controller #(.NUM_RULES(NR), .SETTLE(1), .HUMAN_FIRST(1'b1)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .human_valid_i(human_valid),
      .human_move_i(human_move), .human_ready_o(a_ready), .rule_moves_i(rule_moves),
      .human_board_o(a_hb), .computer_board_o(a_cb), .comp_move_o(a_cm),
      .comp_move_valid_o(a_cmv), .move_error_o(a_err), .game_over_o(a_over), .winner_o(a_win));

   ttt_turn_controller #(.NUM_RULES(NR), .SETTLE(1), .HUMAN_FIRST(1'b0)) dut_cf (
      .clk_i(clk), .reset_i(reset), .start_i(start), .human_valid_i(human_valid),
      .human_move_i(human_move), .human_ready_o(b_ready), .rule_moves_i(rule_moves),
      .human_board_o(b_hb), .computer_board_o(b_cb), .comp_move_o(b_cm),
      .comp_move_valid_o(b_cmv), .move_error_o(b_err), .game_over_o(b_over), .winner_o(b_win));

   ttt_turn_controller #(.NUM_RULES(NR), .SETTLE(0), .HUMAN_FIRST(1'b1)) dut_s0 (
      .clk_i(clk), .reset_i(reset), .start_i(start), .human_valid_i(human_valid),
      .human_move_i(human_move), .human_ready_o(c_ready), .rule_moves_i(rule_moves),
      .human_board_o(c_hb), .computer_board_o(c_cb), .comp_move_o(c_cm),
      .comp_move_valid_o(c_cmv), .move_error_o(c_err), .game_over_o(c_over), .winner_o(c_win));

   int checks = 0;
   int errors = 0;

   // Model: square index 0 = top-left (bit 8) ... 8 = bottom-right (bit 0); 0 empty, 1 human, 2 computer.
   int own[9];
   bit exp_over;
   int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] bits_of(input int who);
      logic [8:0] b;
      b = '0;
      for (int i = 0; i < 9; i++) if (own[i] == who) b[8-i] = 1'b1;
      return b;
   endfunction

   function automatic bit wins(input int who);
      for (int l = 0; l < 8; l++)
         if (own[lines[l][0]] == who && own[lines[l][1]] == who && own[lines[l][2]] == who)
            return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit full();
      for (int i = 0; i < 9; i++) if (own[i] == 0) return 1'b0;
      return 1'b1;
   endfunction

   // Rule k's candidate squares are scanned reading order; first legal square of the first useful rule.
   function automatic int model_pick();
      for (int k = 0; k < NR; k++)
         for (int i = 0; i < 9; i++)
            if (rule_moves[9*k + 8 - i] && own[i] == 0) return i;
      for (int i = 0; i < 9; i++) if (own[i] == 0) return i;
      return -1;
   endfunction

   function automatic logic [8:0] sq(input int i);
      logic [8:0] b;
      b = '0;
      b[8-i] = 1'b1;
      return b;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 9; i++) own[i] = 0;
      exp_over = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ready"}, a_ready, 0);
      chk({tag, "_over"},  a_over, 0);
      chk({tag, "_cmv"},   a_cmv, 0);
      chk({tag, "_err"},   a_err, 0);
      chk({tag, "_win"},   a_win, 0);
      chk({tag, "_hb"},    a_hb, 0);
      chk({tag, "_cb"},    a_cb, 0);
      chk({tag, "_cm"},    a_cm, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; human_valid = 1'b0; human_move = '0; rule_moves = '0;
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      model_clear();
   endtask

   task automatic start_game();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_clear();
      chk("start_ready", a_ready, 1);
      chk("start_hb", a_hb, 0);
      chk("start_cb", a_cb, 0);
      chk("start_over", a_over, 0);
      chk("start_win", a_win, 0);
   endtask

   task automatic end_checks();
      logic [1:0] w;
      w = wins(1) ? 2'b01 : (wins(2) ? 2'b10 : 2'b00);
      chk("over_flag", a_over, 1);
      chk("over_winner", a_win, w);
      chk("over_ready", a_ready, 0);
      chk("over_hb", a_hb, bits_of(1));
      chk("over_cb", a_cb, bits_of(2));
      exp_over = 1'b1;
   endtask

   task automatic hmove(input logic [8:0] mv);
      int n, idx, p;
      n = 0; idx = -1;
      for (int i = 0; i < 9; i++) if (mv[i]) begin n++; idx = 8 - i; end
      chk("ready_before", a_ready, 1);
      human_valid = 1'b1; human_move = mv;
      @(negedge clk);
      human_valid = 1'b0; human_move = '0;
      if (n != 1 || own[idx] != 0) begin
         chk("err_pulse", a_err, 1);
         chk("err_hb", a_hb, bits_of(1));
         chk("err_cb", a_cb, bits_of(2));
         chk("err_ready", a_ready, 1);
         @(negedge clk);
         chk("err_clear", a_err, 0);
         return;
      end
      own[idx] = 1;
      chk("acc_noerr", a_err, 0);
      chk("acc_hb", a_hb, bits_of(1));
      chk("acc_cmv1", a_cmv, 0);
      @(negedge clk);
      if (wins(1) || full()) begin
         chk("hend_cmv", a_cmv, 0);
         end_checks();
         @(negedge clk);
         chk("hend_cmv_late", a_cmv, 0);
         chk("hend_hold", a_over, 1);
         return;
      end
      chk("acc_cmv2", a_cmv, 0);
      @(negedge clk);
      chk("acc_cmv3", a_cmv, 0);
      @(negedge clk);
      p = model_pick();
      own[p] = 2;
      chk("cmv_pulse", a_cmv, 1);
      chk("comp_move", a_cm, sq(p));
      chk("comp_board", a_cb, bits_of(2));
      chk("disjoint", a_hb & a_cb, 0);
      @(negedge clk);
      chk("cmv_single", a_cmv, 0);
      if (wins(2) || full()) end_checks();
      else chk("ready_again", a_ready, 1);
   endtask

   task automatic random_rules();
      logic [8:0] v;
      rule_moves = '0;
      for (int k = 0; k < NR; k++) begin
         case ($urandom_range(0, 3))
            0: v = '0;
            1: v = sq($urandom_range(0, 8));
            default: v = 9'($urandom);
         endcase
         rule_moves[9*k +: 9] = v;
      end
   endtask

   logic [8:0] hm [5] = '{9'b100000000, 9'b000000001, 9'b000000010, 9'b001000000, 9'b000100000};
   logic [8:0] cr [4] = '{9'b000010000, 9'b010000000, 9'b000000100, 9'b000001000};

   initial begin
      reset = 1'b1; start = 1'b0; human_valid = 1'b0; human_move = '0; rule_moves = '0;
      model_clear();

      // Opening move, rejected moves, ignored start, fallback and priority picks.
      do_reset();
      start_game();
      rule_moves[8:0] = 9'b000010000;
      hmove(9'b100000000);
      chk("t1_cm", a_cm, 9'b000010000);
      hmove(9'b100000000);
      hmove(9'b000000011);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_ign_ready", a_ready, 1);
      chk("start_ign_hb", a_hb, 9'b100000000);
      chk("start_ign_cb", a_cb, 9'b000010000);
      rule_moves = '0;
      hmove(9'b000000001);
      chk("t3_fallback", a_cm, 9'b010000000);
      rule_moves[8:0]  = 9'b100000000;
      rule_moves[17:9] = 9'b000001000;
      hmove(9'b000000100);
      chk("t3_priority", a_cm, 9'b000001000);

      // Human wins on the top row.
      do_reset();
      start_game();
      rule_moves[8:0] = 9'b000010000;
      hmove(9'b100000000);
      rule_moves[8:0] = 9'b000001000;
      hmove(9'b010000000);
      rule_moves = '0;
      hmove(9'b001000000);
      chk("t4_winner", a_win, 2'b01);

      // Full board draw; start from OVER must clear everything.
      start_game();
      for (int i = 0; i < 5; i++) begin
         rule_moves = '0;
         if (i < 4) rule_moves[8:0] = cr[i];
         hmove(hm[i]);
      end
      chk("t5_draw", a_win, 2'b00);
      chk("t5_over", a_over, 1);

      // Computer-first: first pulse at start+3.
      do_reset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("cf_cmv1", b_cmv, 0);
      chk("cf_ready1", b_ready, 0);
      @(negedge clk);
      chk("cf_cmv2", b_cmv, 0);
      @(negedge clk);
      chk("cf_cmv3", b_cmv, 1);
      chk("cf_cm", b_cm, 9'b100000000);
      chk("cf_cb", b_cb, 9'b100000000);
      @(negedge clk);
      chk("cf_cmv4", b_cmv, 0);
      chk("cf_ready4", b_ready, 1);

      // SETTLE=0: pulse at handshake+3.
      do_reset();
      start_game();
      chk("s0_ready", c_ready, 1);
      human_valid = 1'b1; human_move = 9'b100000000;
      @(negedge clk);
      human_valid = 1'b0; human_move = '0;
      @(negedge clk);
      chk("s0_cmv2", c_cmv, 0);
      @(negedge clk);
      chk("s0_cmv3", c_cmv, 1);
      chk("s0_cm", c_cm, 9'b010000000);

      // Reset while in SETTLE aborts the game.
      do_reset();
      start_game();
      human_valid = 1'b1; human_move = 9'b000010000;
      @(negedge clk);
      human_valid = 1'b0; human_move = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("settle_rst");
      reset = 1'b0;
      @(negedge clk);
      chk("settle_rst_idle", a_ready, 0);
      chk("settle_rst_cmv", a_cmv, 0);
      model_clear();

      // Random games, each played to completion.
      for (int g = 0; g < 14; g++) begin
         int e[$];
         logic [8:0] bad;
         start_game();
         while (!exp_over) begin
            random_rules();
            if ($urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 2))
                  0: bad = '0;
                  1: begin
                     bad = sq($urandom_range(0, 4));
                     bad = bad | sq($urandom_range(5, 8));
                  end
                  default: begin
                     bad = sq(0);
                     for (int i = 0; i < 9; i++) if (own[i] != 0) bad = sq(i);
                  end
               endcase
               hmove(bad);
            end
            e.delete();
            for (int i = 0; i < 9; i++) if (own[i] == 0) e.push_back(i);
            hmove(sq(e[$urandom_range(0, e.size() - 1)]));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
